serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to load operands and begin an addition.
REQ-005 SHALL have port: a_in  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 SHALL have port: b_in  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 SHALL have port: busy  output  1  high while in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result.
REQ-011 SHALL have port: cout  output  1  registered final carry-out.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; rst forces IDLE.
REQ-013 SHALL accept start only in IDLE or DONE: load A/B shift registers, carry register <= cin, bit counter <= 0, clear sum, go to RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 SHALL, on each RUN edge, compute one full-adder bit from A[0], B[0], carry: s = A0^B0^c, c' = majority(A0,B0,c).
REQ-016 SHALL shift s into sum at MSB with sum shifting right, shift A and B right by one, and store c' in the carry register, each RUN edge.
REQ-017 SHALL process bits LSB first and leave RUN after exactly WIDTH RUN edges, counter then equal to WIDTH-1 on the last.
REQ-018 SHALL go RUN -> DONE after the WIDTH-th RUN edge, and DONE -> IDLE on the next edge unless start is accepted (then -> RUN).
REQ-019 SHALL assert done only in DONE, for exactly one cycle; first done high cycle follows the WIDTH-th edge after the edge that accepted start.
REQ-020 SHALL hold sum and cout (cout = final carry register) stable from DONE until the next accepted start.
REQ-021 SHALL keep busy low in IDLE and DONE; busy and done never high together.
REQ-022 SHALL produce sum/cout equal to the low WIDTH bits and bit WIDTH of a_in + b_in + cin.

Reset
REQ-023 SHALL, on rst assertion at any time including mid-RUN, immediately set state IDLE, busy 0, done 0, sum 0, cout 0, counter 0, carry 0, A/B registers 0.
REQ-024 SHALL ignore start while rst is high; first acceptance is on the first edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDER_OVF_EN defined, add output port ovf (1 bit) = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB, registered alongside cout.
REQ-026 SHALL give ovf the same reset value (0), validity and hold rules as cout.
REQ-027 SHALL, without SERIAL_ADDER_OVF_EN, omit the ovf port and its logic entirely; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 SHALL cover: start with a_in=0x0F, b_in=0x01, cin=0 -> after 8 edges done pulses 1 cycle, sum=0x10, cout=0, busy high exactly 8 cycles.
REQ-029 SHALL cover: a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1; then a_in=0xFF, b_in=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 SHALL cover: start pulsed again at RUN cycle 3 with a_in=0x55 -> ignored, original result delivered on schedule.
REQ-031 SHALL cover: rst asserted at RUN cycle 4 -> state IDLE, sum=0, cout=0, busy=0, done=0 immediately (asynchronously); new start afterward completes correctly.
REQ-032 SHALL cover: start held high through DONE -> back-to-back addition, done pulses every 9 cycles, busy low only during DONE.
REQ-033 SHALL cover (SERIAL_ADDER_OVF_EN): 0x7F+0x01 cin=0 -> sum=0x80, cout=0, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x01+0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: LSB-first, one full-adder bit per clock, WIDTH cycles per sum.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_last;
   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   // One full-adder slice on the current LSBs
   assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath; the final carry (and overflow) is captured separately so it holds through the next load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_busy <= (w_state_nxt == S_RUN);
         r_done <= (w_state_nxt == S_DONE);
         if (w_load) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
         end else if (r_state == S_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            if (w_last) begin
               r_cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
               r_ovf  <= r_carry ^ w_c;
`endif
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): arithmetic reference model plus directed vectors.
// Define SERIAL_ADDER_OVF_EN for both files to exercise the ovf output.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: busy countdown after acceptance, result from plain integer arithmetic
   int           m_left = 0;
   bit           m_done = 1'b0;
   logic [W:0]   m_pend = '0;
   logic [W:0]   m_out = '0;
   bit           m_povf = 1'b0;
   bit           m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_out  = '0;
         m_ovf  = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_out  = m_pend;
            m_ovf  = m_povf;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            int r;
            m_pend = (W+1)'(a_in) + (W+1)'(b_in) + (W+1)'(cin);
            r = int'($signed(a_in)) + int'($signed(b_in)) + int'(cin);
            m_povf = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
            m_left = W;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("cyc_busy", 32'(busy), 32'(m_left > 0));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_overlap", 32'(busy & done), 32'd0);
         if (m_left == 0) begin
            check("cyc_sum", 32'(sum), 32'(m_out[W-1:0]));
            check("cyc_cout", 32'(cout), 32'(m_out[W]));
`ifdef SERIAL_ADDER_OVF_EN
            check("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
         end
      end
   end

   // One addition with literal expectations; glitch >= 0 pulses start (a_in=0x55) mid-RUN
   task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int glitch);
      int  nbusy;
      bit  seen;
      nbusy = 0;
      seen  = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; a_in = a; b_in = b; cin = c;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nbusy++;
         if (k == glitch) begin
            start = 1'b1; a_in = 8'h55;
         end else if (k == glitch + 1) begin
            start = 1'b0;
         end
      end
      check({nm, "_done_seen"}, 32'(seen), 32'd1);
      check({nm, "_busy_cycles"}, 32'(nbusy), 32'(W));
      check({nm, "_sum"}, 32'(sum), 32'(es));
      check({nm, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) check({nm, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
      @(negedge clk);
      check({nm, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int t_done[$];
      int cyc;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, -1);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
      run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, -1);
      run_op("add_f0_0f_c", 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, -1);
      run_op("ignore_start", 8'h3C, 8'h0A, 1'b1, 8'h47, 1'b0, 1'b0, 2);

      // Asynchronous reset in the middle of RUN
      @(posedge clk); #1;
      start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_cout", 32'(cout), 32'd0);
      #1 rst = 1'b0;
      run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, -1);

      // start held high: back-to-back additions every WIDTH+1 cycles
      @(posedge clk); #1;
      start = 1'b1; a_in = 8'h80; b_in = 8'h80; cin = 1'b0;
      cyc = 0;
      while (t_done.size() < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done) t_done.push_back(cyc);
      end
      start = 1'b0;
      check("b2b_count", 32'(t_done.size()), 32'd3);
      if (t_done.size() == 3) begin
         check("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'(W + 1));
         check("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'(W + 1));
      end
      repeat (W + 3) @(negedge clk);

      run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
      run_op("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
      run_op("ovf_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
